qr_gs_sequencer: RTL

// Control sequencer for the QR decomposition datapath. Loads an N x N matrix streamed on a_in

---
 rtl/qr_gs_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/qr_gs_sequencer.sv
// Sequencer for the QR (modified Gram-Schmidt) datapath: loads an N x N matrix, then issues NORM/SCALE/DOT/AXPY ops.
// Latency: ld_* one cycle after a_valid; next op_valid one cycle after rsp_valid; done one cycle after the last response.
// Backpressure: op fields are held while op_valid && !op_ready; one op outstanding; a watchdog aborts a stalled WAIT with err.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   start                       begins a run (sampled in IDLE only)
//   a_valid, a_in               column-major matrix element stream
//   ld_we, ld_addr, ld_data     registered write port into the datapath matrix store
//   op_valid/op_ready, op_code, op_i, op_j   command port to the arithmetic unit
//   rsp_valid                   completion of the accepted command
//   busy, done, err             status: not IDLE, run complete pulse, watchdog abort pulse
module qr_gs_sequencer #(
  parameter int N       = 3,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          a_valid,
  input  logic [DW-1:0] a_in,
  output logic          ld_we,
  output logic [3:0]    ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [1:0]    op_code,
  output logic [1:0]    op_i,
  output logic [1:0]    op_j,
  input  logic          rsp_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  // Phase encoding doubles as the op_code driven on the command port.
  localparam logic [1:0] PH_NORM  = 2'd0;
  localparam logic [1:0] PH_SCALE = 2'd1;
  localparam logic [1:0] PH_DOT   = 2'd2;
  localparam logic [1:0] PH_AXPY  = 2'd3;

  localparam logic [3:0] LAST_EL = 4'(N * N - 1);
  localparam logic [1:0] LAST_J  = 2'(N - 1);

  localparam int         WW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state, state_nxt;
  logic [3:0]      el_cnt;
  logic [1:0]      col_j;
  logic [1:0]      row_i;
  logic [1:0]      phase;
  logic [WW-1:0]   wdog;
  logic            last_op;
  logic            handshake;

  assign last_op   = (phase == PH_SCALE) && (col_j == LAST_J);
  assign handshake = (state == S_ISSUE) && op_ready;

  always_comb begin
    state_nxt = state;
    op_valid  = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    op_code   = 2'd0;
    op_i      = 2'd0;
    op_j      = 2'd0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (a_valid && (el_cnt == LAST_EL)) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        op_valid = 1'b1;
        op_code  = phase;
        op_j     = col_j;
        // Only DOT/AXPY carry a source column.
        op_i     = phase[1] ? row_i : 2'd0;
        if (op_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response in the expiry cycle takes priority over the watchdog.
        if (rsp_valid) begin
          state_nxt = last_op ? S_FIN : S_ISSUE;
        end else if ((TIMEOUT != 0) && (wdog == WD_LAST)) begin
          err       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load path: registered copy of the element stream with its store address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_we   <= 1'b0;
      ld_addr <= 4'd0;
      ld_data <= '0;
      el_cnt  <= 4'd0;
    end else begin
      ld_we <= 1'b0;
      if ((state == S_IDLE) && start) begin
        el_cnt <= 4'd0;
      end else if ((state == S_LOAD) && a_valid) begin
        ld_we   <= 1'b1;
        ld_addr <= el_cnt;
        ld_data <= a_in;
        el_cnt  <= el_cnt + 4'd1;
      end
    end
  end

  // Op pointer (j, i, phase) walks: per column j, {DOT,AXPY} for each i<j, then NORM, SCALE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_j <= 2'd0;
      row_i <= 2'd0;
      phase <= PH_NORM;
    end else if ((state == S_IDLE) && start) begin
      col_j <= 2'd0;
      row_i <= 2'd0;
      phase <= PH_NORM;
    end else if ((state == S_WAIT) && rsp_valid) begin
      case (phase)
        PH_DOT:  phase <= PH_AXPY;
        PH_AXPY: begin
          if ((row_i + 2'd1) < col_j) begin
            row_i <= row_i + 2'd1;
            phase <= PH_DOT;
          end else begin
            phase <= PH_NORM;
          end
        end
        PH_NORM: phase <= PH_SCALE;
        default: begin
          // SCALE closes a column; column j>0 always opens with DOT(0,j).
          if (!last_op) begin
            col_j <= col_j + 2'd1;
            row_i <= 2'd0;
            phase <= PH_DOT;
          end
        end
      endcase
    end
  end

  // Watchdog: zeroed when a command is accepted, counts silent WAIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
    end else if (handshake) begin
      wdog <= '0;
    end else if ((state == S_WAIT) && !rsp_valid) begin
      wdog <= wdog + 1'b1;
    end
  end

endmodule
